rr_grant_ctrl: RTL and testbench
================================

// Module: rr_grant_ctrl
// PURPOSE
//   Grant-issue stage of the round-robin arbiter, directly downstream of the
//   next-grant priority-mask stage. Picks one requester from the registered
//   next_grant_mask and offers it to the shared resource with a valid/ready
//   handshake. It holds ownership for up to MAX_BEATS beats, then feeds the
//   served grant back upstream on grant_last so the priority mask rotates.
// PARAMETERS
//   N          4  number of requesters (>=2)
//   MAX_BEATS  4  max beats per ownership (fairness limit, >=1)
//   SETTLE_CYC 2  idle cycles after release; matches the 2-cycle latency of
//                 the mask stage from grant_last to next_grant_mask (>=1)
// PORTS
//   clk             in   1          clock, rising edge
//   reset           in   1          synchronous, active-high reset
//   request         in   N          raw requests, one bit per requester
//   next_grant_mask in   N          registered priority-filtered requests from mask stage
//   grant_ready     in   1          resource accepts offered grant
//   beat            in   1          one data beat transferred by current owner
//   last            in   1          qualifies beat: final beat of transaction
//   grant           out  N          one-hot current offer/owner; 0 when none
//   grant_valid     out  1          offer pending (OFFER state)
//   owner_id        out  clog2(N)   binary index of grant; 0 when grant==0
//   busy            out  1          ownership active (BUSY state)
//   grant_last      out  N          one-hot last accepted grant; drives mask stage grant input
// BEHAVIOUR
//   Reset (sync, active-high): state IDLE; grant=0, grant_valid=0, busy=0, owner_id=0.
//     Also grant_last=1<<(N-1), so the first rotation gives priority from bit 0.
//     beat_cnt=0, settle_cnt=0. Reset has priority over every other event in any state.
//   All outputs are registered. FSM states: IDLE, OFFER, BUSY, SETTLE.
//   IDLE: if request!=0, cand = next_grant_mask & request.
//     The lowest set bit of cand is picked; if cand==0, the lowest set bit of request.
//     Next cycle: grant=pick, grant_valid=1, -> OFFER. Request-to-offer latency is 1 cycle.
//   OFFER: grant and grant_valid held stable.
//     grant_ready=1: -> BUSY; grant_valid=0, busy=1, grant_last<=grant, beat_cnt=0.
//     Else if request[owner_id]==0: withdraw; grant=0, grant_valid=0, -> IDLE.
//       grant_last is not changed on withdraw.
//     ready and request drop in the same cycle: ready wins (accepted).
//   BUSY: beat=1 increments beat_cnt (width clog2(MAX_BEATS+1)). Release when any of:
//       (a) beat&&last;
//       (b) beat && beat_cnt==MAX_BEATS-1;
//       (c) request[owner_id]==0.
//     Release: grant=0, busy=0, owner_id=0, settle_cnt=SETTLE_CYC-1, -> SETTLE.
//     last without beat is ignored. Beats outside BUSY are ignored.
//   SETTLE: no offer; settle_cnt decrements; at 0 -> IDLE. The next offer therefore
//     appears SETTLE_CYC+1 cycles after release, using an updated next_grant_mask.
//   grant_last is written only on acceptance and is always one-hot.
//   grant is one-hot or zero at all times.
//   A request arriving in SETTLE or BUSY waits; nothing is queued beyond the request level.
// TESTING (N=4, MAX_BEATS=4, SETTLE_CYC=2)
//   1 reset; request=0110, mask=1111 -> next cycle grant=0010, grant_valid=1, owner_id=1.
//   2 IDLE, request=0011, mask=1100 (masked empty) -> grant=0001 (fallback to raw request).
//   3 accept, then beat=1 every cycle with no last -> release after 4th beat, grant=0;
//     grant_last=accepted grant; next offer 3 cycles after release.
//   4 OFFER, ready=0, owner's request drops -> grant=0 next cycle, IDLE, grant_last unchanged.
//   5 BUSY, beat+last on 2nd beat -> release; beat_cnt reset; SETTLE for 2 cycles.
//   6 reset asserted mid-BUSY -> next edge: all outputs at reset values, grant_last=1000.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// Grant-issue stage of the round-robin arbiter: offers one requester from the
// priority-filtered mask, holds ownership for a bounded number of beats, feeds grant_last back.
module rr_grant_ctrl #(
  parameter int N          = 4,
  parameter int MAX_BEATS  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         request,
  input  logic [N-1:0]         next_grant_mask,
  input  logic                 grant_ready,
  input  logic                 beat,
  input  logic                 last,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] owner_id,
  output logic                 busy,
  output logic [N-1:0]         grant_last
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, BUSY, SETTLE} state_e;

  state_e             state_q;
  logic [N-1:0]       grant_q;
  logic               grant_valid_q;
  logic               busy_q;
  logic [IDX_W-1:0]   owner_id_q;
  logic [N-1:0]       grant_last_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [SET_W-1:0]   settle_cnt_q;

  logic [N-1:0]       cand;
  logic [N-1:0]       pick_src;
  logic [IDX_W-1:0]   pick_idx_d;
  logic [N-1:0]       pick_d;
  logic               release_d;

  // Prefer the rotated priority view; fall back to raw requests when it is empty.
  always_comb begin
    cand       = next_grant_mask & request;
    pick_src   = (cand != '0) ? cand : request;
    pick_idx_d = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_src[i]) pick_idx_d = IDX_W'(i);
    end
    pick_d = N'(1) << pick_idx_d;
  end

  assign release_d = (beat && last)
                  || (beat && (beat_cnt_q == CNT_W'(MAX_BEATS - 1)))
                  || !request[owner_id_q];

  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // and the synchronous reset branch comes first so it overrides any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      owner_id_q    <= '0;
      grant_last_q  <= {1'b1, {(N-1){1'b0}}};
      beat_cnt_q    <= '0;
      settle_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request != '0) begin
            grant_q       <= pick_d;
            owner_id_q    <= pick_idx_d;
            grant_valid_q <= 1'b1;
            state_q       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b1;
            grant_last_q  <= grant_q;
            beat_cnt_q    <= '0;
            state_q       <= BUSY;
          end else if (!request[owner_id_q]) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            owner_id_q    <= '0;
            state_q       <= IDLE;
          end
        end
        BUSY: begin
          if (release_d) begin
            grant_q      <= '0;
            busy_q       <= 1'b0;
            owner_id_q   <= '0;
            beat_cnt_q   <= '0;
            settle_cnt_q <= SET_W'(SETTLE_CYC - 1);
            state_q      <= SETTLE;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          // Gives the mask stage time to absorb the new grant_last.
          if (settle_cnt_q == '0) state_q <= IDLE;
          else                    settle_cnt_q <= settle_cnt_q - SET_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign busy        = busy_q;
  assign owner_id    = owner_id_q;
  assign grant_last  = grant_last_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Table-driven bench for rr_grant_ctrl with a scoreboard queue of expected outputs.
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] next_grant_mask;
  logic       grant_ready;
  logic       beat;
  logic       last;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] owner_id;
  logic       busy;
  logic [3:0] grant_last;

  rr_grant_ctrl #(.N(4), .MAX_BEATS(4), .SETTLE_CYC(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .request         (request),
    .next_grant_mask (next_grant_mask),
    .grant_ready     (grant_ready),
    .beat            (beat),
    .last            (last),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .owner_id        (owner_id),
    .busy            (busy),
    .grant_last      (grant_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       rdy;
    logic       bt;
    logic       lst;
    logic [3:0] g;
    logic       gv;
    logic [1:0] own;
    logic       bsy;
    logic [3:0] gl;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic       gv;
    logic [1:0] own;
    logic       bsy;
    logic [3:0] gl;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] mask,
                              logic rdy, logic bt, logic lst,
                              logic [3:0] g, logic gv, logic [1:0] own,
                              logic bsy, logic [3:0] gl);
    vec_t v;
    v.rst = rst; v.req = req; v.mask = mask; v.rdy = rdy; v.bt = bt; v.lst = lst;
    v.g = g; v.gv = gv; v.own = own; v.bsy = bsy; v.gl = gl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    exp_t got;
    reset = v.rst; request = v.req; next_grant_mask = v.mask;
    grant_ready = v.rdy; beat = v.bt; last = v.lst;
    e.tag = tag; e.g = v.g; e.gv = v.gv; e.own = v.own; e.bsy = v.bsy; e.gl = v.gl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".grant"},       32'(grant),       32'(got.g));
    check({got.tag, ".grant_valid"}, 32'(grant_valid), 32'(got.gv));
    check({got.tag, ".owner_id"},    32'(owner_id),    32'(got.own));
    check({got.tag, ".busy"},        32'(busy),        32'(got.bsy));
    check({got.tag, ".grant_last"},  32'(grant_last),  32'(got.gl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; request = '0; next_grant_mask = '0;
    grant_ready = 1'b0; beat = 1'b0; last = 1'b0;

    //             rst req      mask     rdy bt lst  grant    gv own   bsy gl
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b1000)); // reset
    tbl.push_back(mk(0, 4'b0110, 4'b1111, 0, 0, 0, 4'b0010, 1, 2'd1, 0, 4'b1000)); // first offer
    tbl.push_back(mk(0, 4'b0110, 4'b1111, 1, 0, 0, 4'b0010, 0, 2'd1, 1, 4'b0010)); // accept
    tbl.push_back(mk(0, 4'b0110, 4'b1111, 0, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010)); // beat 1
    tbl.push_back(mk(0, 4'b0110, 4'b1111, 0, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010)); // beat 2
    tbl.push_back(mk(0, 4'b0110, 4'b1111, 0, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010)); // beat 3
    tbl.push_back(mk(0, 4'b0110, 4'b1111, 0, 1, 0, 4'b0000, 0, 2'd0, 0, 4'b0010)); // beat 4 -> release
    tbl.push_back(mk(0, 4'b0110, 4'b1100, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b0010)); // settle
    tbl.push_back(mk(0, 4'b0110, 4'b1100, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b0010)); // settle -> idle
    tbl.push_back(mk(0, 4'b0110, 4'b1100, 0, 0, 0, 4'b0100, 1, 2'd2, 0, 4'b0010)); // offer 3 after release
    tbl.push_back(mk(0, 4'b0010, 4'b1100, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b0010)); // withdraw
    tbl.push_back(mk(0, 4'b0011, 4'b1100, 0, 0, 0, 4'b0001, 1, 2'd0, 0, 4'b0010)); // fallback pick
    tbl.push_back(mk(0, 4'b0000, 4'b1100, 1, 0, 0, 4'b0001, 0, 2'd0, 1, 4'b0001)); // ready beats drop
    tbl.push_back(mk(0, 4'b0001, 4'b1100, 0, 0, 1, 4'b0001, 0, 2'd0, 1, 4'b0001)); // last w/o beat
    tbl.push_back(mk(0, 4'b0001, 4'b1100, 0, 1, 0, 4'b0001, 0, 2'd0, 1, 4'b0001)); // beat 1
    tbl.push_back(mk(0, 4'b0001, 4'b1100, 0, 1, 1, 4'b0000, 0, 2'd0, 0, 4'b0001)); // beat 2 + last
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b0001)); // settle
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b0001)); // settle -> idle
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 1, 2'd2, 0, 4'b0001)); // offer
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 0, 2'd2, 1, 4'b0100)); // accept
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100, 0, 2'd2, 1, 4'b0100)); // beat 1
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 1, 0, 4'b0000, 0, 2'd0, 0, 4'b1000)); // reset mid-busy
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b1000)); // idle, no request
    tbl.push_back(mk(0, 4'b1001, 4'b1000, 0, 0, 0, 4'b1000, 1, 2'd3, 0, 4'b1000)); // masked pick
    tbl.push_back(mk(0, 4'b1001, 4'b1000, 0, 0, 0, 4'b1000, 1, 2'd3, 0, 4'b1000)); // hold offer
    tbl.push_back(mk(0, 4'b1001, 4'b1000, 1, 0, 0, 4'b1000, 0, 2'd3, 1, 4'b1000)); // accept
    tbl.push_back(mk(0, 4'b0001, 4'b1000, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b1000)); // owner drops

    for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i]);

    // Beats with gaps still reach the MAX_BEATS limit; beat in SETTLE is ignored.
    step("gap_settle", mk(0, 4'b0000, 4'b1111, 0, 1, 0, 4'b0000, 0, 2'd0, 0, 4'b1000));
    step("gap_idle",   mk(0, 4'b0000, 4'b1111, 0, 1, 0, 4'b0000, 0, 2'd0, 0, 4'b1000));
    step("gap_offer",  mk(0, 4'b0010, 4'b1111, 0, 0, 0, 4'b0010, 1, 2'd1, 0, 4'b1000));
    step("gap_accept", mk(0, 4'b0010, 4'b1111, 1, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010));
    step("gap_b1",     mk(0, 4'b0010, 4'b1111, 0, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010));
    step("gap_n1",     mk(0, 4'b0010, 4'b1111, 0, 0, 0, 4'b0010, 0, 2'd1, 1, 4'b0010));
    step("gap_b2",     mk(0, 4'b0010, 4'b1111, 0, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010));
    step("gap_n2",     mk(0, 4'b0010, 4'b1111, 0, 0, 0, 4'b0010, 0, 2'd1, 1, 4'b0010));
    step("gap_b3",     mk(0, 4'b0010, 4'b1111, 0, 1, 0, 4'b0010, 0, 2'd1, 1, 4'b0010));
    step("gap_b4",     mk(0, 4'b0010, 4'b1111, 0, 1, 0, 4'b0000, 0, 2'd0, 0, 4'b0010));
    step("gap_post",   mk(0, 4'b0010, 4'b1111, 0, 0, 0, 4'b0000, 0, 2'd0, 0, 4'b0010));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
